// File: rtl/level_pkg.sv
// level_pkg: game state codes, lane encoding and helpers shared by level and player logic.
package level_pkg;
   localparam logic [3:0] TITLE    = 4'd0;
   localparam logic [3:0] TITLE1   = 4'd1;
   localparam logic [3:0] TITLE2   = 4'd2;
   localparam logic [3:0] TITLE3   = 4'd3;
   localparam logic [3:0] TITLE4   = 4'd4;
   localparam logic [3:0] RUN1     = 4'd5;
   localparam logic [3:0] RUN2     = 4'd6;
   localparam logic [3:0] JUMP1    = 4'd7;
   localparam logic [3:0] JUMP2    = 4'd8;
   localparam logic [3:0] DUCK1    = 4'd9;
   localparam logic [3:0] DUCK2    = 4'd10;
   localparam logic [3:0] IDLE     = 4'd11;
   localparam logic [3:0] CHARSEL0 = 4'd12;
   localparam logic [3:0] CHARSEL1 = 4'd13;
   typedef enum logic [1:0] {LANE_NONE, LANE_LOW, LANE_MID, LANE_HIGH} lane_e;
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   function automatic logic is_running(input logic [3:0] s);
      return s >= RUN1 && s <= DUCK2;
   endfunction
endpackage

// File: rtl/lfsr16.sv
// lfsr16: 16-bit Fibonacci LFSR (taps 16,14,13,11), advances one step per asserted step.
module lfsr16
   import level_pkg::*;
(
   input  logic        Clk,
   input  logic        Reset,
   input  logic        step,
   output logic [15:0] value
);
   logic [15:0] value_q, value_d;
   always_comb value_d = step ? {value_q[14:0], value_q[15] ^ value_q[13] ^ value_q[12] ^ value_q[10]} : value_q;
   always_ff @(posedge Clk) begin
      if (Reset) value_q <= LFSR_SEED;
      else       value_q <= value_d;
   end
   assign value = value_q;
endmodule

// File: rtl/obstacle_scheduler.sv
// obstacle_scheduler: per-frame obstacle spawning, leftward scrolling and retirement,
// with a randomised spawn cooldown and speed ramp every few spawns.
module obstacle_scheduler
   import level_pkg::*;
#(
   parameter int          NUM_OBS       = 4,
   parameter int          CORDW         = 10,
   parameter int          X_SPAWN       = 750,
   parameter int          X_LEFT        = 170,
   parameter int          MIN_GAP       = 24,
   parameter logic [5:0]  GAP_MASK      = 6'h1F,
   parameter int          SPEED_INIT    = 2,
   parameter int          SPEED_MAX     = 6,
   parameter int          SPEEDUP_EVERY = 8
)(
   input  logic                     Clk,
   input  logic                     Reset,
   input  logic                     frame_tick,
   input  logic [3:0]               state,
   output logic [NUM_OBS-1:0]       obs_valid,
   output logic [NUM_OBS*CORDW-1:0] obs_x,
   output logic [2*NUM_OBS-1:0]     obs_lane,
   output logic                     spawn_pulse,
   output logic [2:0]               speed
);
   localparam int CW = $clog2(SPEEDUP_EVERY);
   logic [15:0] r;
   logic title, upd, spawn, ramp;
   logic [NUM_OBS-1:0] valid_q, valid_d, pick;
   logic [NUM_OBS-1:0][CORDW-1:0] x_q, x_d;
   logic [NUM_OBS-1:0][1:0] lane_q, lane_d;
   logic [5:0] cd_q, cd_d, reload;
   logic [2:0] speed_q, speed_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic spawn_q;

   lfsr16 u_lfsr (.Clk(Clk), .Reset(Reset), .step(frame_tick), .value(r));

   assign title  = state == TITLE;
   assign upd    = frame_tick && is_running(state);
   // lowest free slot as one-hot, judged on occupancy before this frame's retirements
   assign pick   = ~valid_q & (valid_q + 1'b1);
   assign spawn  = upd && cd_q == '0 && r[1:0] != LANE_NONE && !(&valid_q);
   assign reload = 6'(MIN_GAP) + (r[7:2] & GAP_MASK);
   assign ramp   = cnt_q == CW'(SPEEDUP_EVERY - 1);

   always_comb begin
      valid_d = valid_q;
      x_d     = x_q;
      lane_d  = lane_q;
      for (int i = 0; i < NUM_OBS; i++) begin
         if (title) begin
            valid_d[i] = 1'b0;
            x_d[i]     = '0;
            lane_d[i]  = '0;
         end else if (spawn && pick[i]) begin
            valid_d[i] = 1'b1;
            x_d[i]     = CORDW'(X_SPAWN);
            lane_d[i]  = r[1:0];
         end else if (upd && valid_q[i]) begin
            if (x_q[i] < CORDW'(X_LEFT) + CORDW'(speed_q)) valid_d[i] = 1'b0;
            else                                           x_d[i] = x_q[i] - CORDW'(speed_q);
         end
      end
   end

   always_comb begin
      cd_d    = cd_q;
      speed_d = speed_q;
      cnt_d   = cnt_q;
      if (title) begin
         cd_d    = 6'(MIN_GAP);
         speed_d = 3'(SPEED_INIT);
         cnt_d   = '0;
      end else if (upd) begin
         // a blocked attempt (all slots busy) leaves the cooldown at zero to retry next frame
         if (cd_q != '0)                         cd_d = cd_q - 1'b1;
         else if (spawn || r[1:0] == LANE_NONE) cd_d = reload;
         if (spawn) begin
            cnt_d   = ramp ? '0 : cnt_q + 1'b1;
            speed_d = (ramp && speed_q < 3'(SPEED_MAX)) ? speed_q + 1'b1 : speed_q;
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         valid_q <= '0;
         x_q     <= '0;
         lane_q  <= '0;
         cd_q    <= 6'(MIN_GAP);
         speed_q <= 3'(SPEED_INIT);
         cnt_q   <= '0;
         spawn_q <= 1'b0;
      end else begin
         valid_q <= valid_d;
         x_q     <= x_d;
         lane_q  <= lane_d;
         cd_q    <= cd_d;
         speed_q <= speed_d;
         cnt_q   <= cnt_d;
         spawn_q <= spawn;
      end
   end

   assign obs_valid   = valid_q;
   assign obs_x       = x_q;
   assign obs_lane    = lane_q;
   assign spawn_pulse = spawn_q;
   assign speed       = speed_q;
endmodule

// File: tb/tb_obstacle_scheduler.sv
// tb_obstacle_scheduler: reference-model scoreboard for obstacle_scheduler; expected
// outputs are queued as each Clk is driven and compared one Clk later.
module tb_obstacle_scheduler;
   import level_pkg::*;

   logic Clk = 1'b0;
   logic Reset, frame_tick;
   logic [3:0] state;
   logic [3:0] obs_valid;
   logic [39:0] obs_x;
   logic [7:0] obs_lane;
   logic spawn_pulse;
   logic [2:0] speed;

   obstacle_scheduler dut (
      .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .state(state),
      .obs_valid(obs_valid), .obs_x(obs_x), .obs_lane(obs_lane),
      .spawn_pulse(spawn_pulse), .speed(speed)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic [3:0]  v;
      logic [39:0] x;
      logic [7:0]  ln;
      logic        p;
      logic [2:0]  sp;
      int          slot;
   } exp_t;
   exp_t sb[$];

   int n_checks = 0;
   int n_fail = 0;

   bit          m_valid[4];
   int          m_x[4];
   logic [1:0]  m_lane[4];
   int          m_speed, m_cd, m_cnt, m_total, m_slot;
   logic [15:0] m_lfsr;
   bit          m_pulse;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_step(input bit rst, input bit tick, input logic [3:0] st);
      logic [15:0] rv;
      int free;
      m_pulse = 1'b0;
      if (rst) begin
         foreach (m_valid[i]) begin m_valid[i] = 0; m_x[i] = 0; m_lane[i] = 0; end
         m_speed = 2; m_cd = 24; m_cnt = 0; m_lfsr = 16'hACE1;
         return;
      end
      rv = m_lfsr;
      if (tick) m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
      if (st == 4'd0) begin
         foreach (m_valid[i]) begin m_valid[i] = 0; m_x[i] = 0; m_lane[i] = 0; end
         m_speed = 2; m_cd = 24; m_cnt = 0;
      end else if (tick && st >= 4'd5 && st <= 4'd10) begin
         free = -1;
         for (int i = 0; i < 4; i++) if (!m_valid[i] && free < 0) free = i;
         for (int i = 0; i < 4; i++)
            if (m_valid[i]) begin
               if (m_x[i] < 170 + m_speed) m_valid[i] = 0;
               else m_x[i] -= m_speed;
            end
         if (m_cd > 0) m_cd--;
         else if (rv[1:0] == 2'd0) m_cd = 24 + int'(rv[7:2] & 6'h1F);
         else if (free >= 0) begin
            m_valid[free] = 1; m_x[free] = 750; m_lane[free] = rv[1:0];
            m_cd = 24 + int'(rv[7:2] & 6'h1F);
            m_pulse = 1; m_slot = free; m_total++;
            if (m_cnt == 7) begin
               m_cnt = 0;
               if (m_speed < 6) m_speed++;
            end else m_cnt++;
         end
      end
   endtask

   task automatic cycle(input bit rst, input bit tick, input logic [3:0] st);
      exp_t e;
      Reset = rst; frame_tick = tick; state = st;
      model_step(rst, tick, st);
      for (int i = 0; i < 4; i++) begin
         e.v[i] = m_valid[i];
         e.x[i*10 +: 10] = 10'(m_x[i]);
         e.ln[i*2 +: 2] = m_lane[i];
      end
      e.p = m_pulse; e.sp = 3'(m_speed); e.slot = m_slot;
      sb.push_back(e);
      @(posedge Clk);
      #1;
      e = sb.pop_front();
      check("obs_valid", 64'(obs_valid), 64'(e.v));
      check("obs_x", 64'(obs_x), 64'(e.x));
      check("obs_lane", 64'(obs_lane), 64'(e.ln));
      check("spawn_pulse", 64'(spawn_pulse), 64'(e.p));
      check("speed", 64'(speed), 64'(e.sp));
      if (e.p) check("spawn_at_x750", 64'(obs_x[e.slot*10 +: 10]), 64'd750);
   endtask

   initial begin
      logic [3:0] run_states[6];
      int frames;
      run_states = '{RUN1, RUN2, JUMP1, JUMP2, DUCK1, DUCK2};
      m_total = 0; m_slot = 0;
      repeat (3) cycle(1, 0, TITLE);
      check("reset_speed", 64'(speed), 64'd2);
      check("reset_valid", 64'(obs_valid), 64'd0);
      check("reset_pulse", 64'(spawn_pulse), 64'd0);
      repeat (20) cycle(0, 0, RUN1);
      check("no_tick_valid", 64'(obs_valid), 64'd0);
      frames = 0;
      while (m_total < 42 && frames < 6000) begin
         cycle(0, 1, run_states[(frames / 100) % 6]);
         if (m_pulse && m_total == 8) check("speed_after_8", 64'(speed), 64'd3);
         if (m_pulse && m_total == 40) check("speed_after_40", 64'(speed), 64'd6);
         cycle(0, 0, run_states[(frames / 100) % 6]);
         frames++;
      end
      check("spawn_budget", 64'(m_total >= 42), 64'd1);
      repeat (6) cycle(0, 1, RUN2);
      repeat (50) cycle(0, 1, IDLE);
      repeat (30) begin cycle(0, 1, RUN1); cycle(0, 0, RUN1); end
      repeat (2) cycle(0, 1, TITLE);
      check("title_speed", 64'(speed), 64'd2);
      check("title_valid", 64'(obs_valid), 64'd0);
      repeat (60) begin cycle(0, 1, RUN1); cycle(0, 0, RUN1); end
      cycle(1, 1, RUN1);
      check("reset_tick_pulse", 64'(spawn_pulse), 64'd0);
      check("reset_tick_speed", 64'(speed), 64'd2);
      check("reset_tick_valid", 64'(obs_valid), 64'd0);
      repeat (40) begin cycle(0, 1, RUN1); cycle(0, 0, RUN1); end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
